// File: rtl/psw_evt_dec.sv
// psw_evt_dec: classifies debounced push-switch pulses into SINGLE/DOUBLE
// press events per key, queues them in a small FIFO and presents them to
// the consumer with a VALID/ACK handshake.
// Optional build macro: PSW_EVT_CNT_EN adds EVT_CNT, a wrapping count of
// events popped by the consumer.
//
// Handshake: EVT_VALID/EVT_CODE are driven only from registered FIFO state.
// An event is consumed in any cycle where EVT_VALID && EVT_ACK are both high
// at the rising CLK edge; EVT_ACK while EVT_VALID is low has no effect. The
// consumer may hold EVT_ACK high to drain one event per cycle.
module psw_evt_dec #(
    parameter int DBL_WIN = 200,   // double-press window in CLK cycles (>= 2)
    parameter int CNT_W   = 23,    // window counter width, holds DBL_WIN-1
    parameter int FIFO_AW = 2      // FIFO depth = 2**FIFO_AW
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [3:0] PSW_SIG,
    input  logic       EVT_ACK,
    input  logic       OVF_CLR,
    output logic       EVT_VALID,
    output logic [2:0] EVT_CODE,
    output logic       EVT_OVF
`ifdef PSW_EVT_CNT_EN
    ,
    output logic [7:0] EVT_CNT
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic {
        KEY_IDLE  = 1'b0,
        KEY_WAIT2 = 1'b1
    } key_state_t;

    // Per-key FSM state; readable hierarchically for debug and checkers.
    key_state_t       key_state   [4];
    key_state_t       key_state_d [4];
    logic [CNT_W-1:0] cnt_q       [4];
    logic [CNT_W-1:0] cnt_d       [4];
    logic [3:0]       emit;
    logic [3:0]       emit_dbl;

    // Pending event holding registers, one per key.
    logic [3:0]       pend_q;
    logic [3:0]       pend_d;
    logic [2:0]       pcode_q [4];
    logic [1:0]       sel;
    logic             wr_en;
    logic [3:0]       wr_hit;
    logic [3:0]       ovf_hit;

    // FIFO storage and pointers (extra MSB separates full from empty).
    logic [2:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;

    // Per-key next state: start the window, detect second press or timeout.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            key_state_d[k] = key_state[k];
            cnt_d[k]       = cnt_q[k];
            emit[k]        = 1'b0;
            emit_dbl[k]    = 1'b0;
            case (key_state[k])
                KEY_IDLE: begin
                    if (PSW_SIG[k]) begin
                        key_state_d[k] = KEY_WAIT2;
                        cnt_d[k]       = CNT_W'(DBL_WIN - 1);
                    end
                end
                KEY_WAIT2: begin
                    // A second press wins over a timeout in the same cycle.
                    if (PSW_SIG[k]) begin
                        emit[k]        = 1'b1;
                        emit_dbl[k]    = 1'b1;
                        key_state_d[k] = KEY_IDLE;
                    end else if (cnt_q[k] == '0) begin
                        emit[k]        = 1'b1;
                        key_state_d[k] = KEY_IDLE;
                    end else begin
                        cnt_d[k] = cnt_q[k] - CNT_W'(1);
                    end
                end
                default: key_state_d[k] = KEY_IDLE;
            endcase
        end
    end

    // Per-key state and window counter registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < 4; k++) begin
                key_state[k] <= KEY_IDLE;
                cnt_q[k]     <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                key_state[k] <= key_state_d[k];
                cnt_q[k]     <= cnt_d[k];
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = !empty && EVT_ACK;

    // Arbiter: lowest pending key gets the single FIFO write slot; a full
    // FIFO blocks the write even when a pop happens in the same cycle.
    always_comb begin
        sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[k]) sel = 2'(k);
        end
        wr_en = (|pend_q) && !full;
        for (int k = 0; k < 4; k++) begin
            wr_hit[k]  = wr_en && (sel == 2'(k));
            ovf_hit[k] = emit[k] && pend_q[k] && !wr_hit[k];
            pend_d[k]  = emit[k] || (pend_q[k] && !wr_hit[k]);
        end
    end

    // Pending flags and codes; a newer emit overwrites an unwritten code.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend_q <= '0;
            for (int k = 0; k < 4; k++) pcode_q[k] <= '0;
        end else begin
            pend_q <= pend_d;
            for (int k = 0; k < 4; k++) begin
                if (emit[k]) pcode_q[k] <= {emit_dbl[k], 2'(k)};
            end
        end
    end

    // Sticky overflow flag; a new loss in the clear cycle keeps it set.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            EVT_OVF <= 1'b0;
        end else if (|ovf_hit) begin
            EVT_OVF <= 1'b1;
        end else if (OVF_CLR) begin
            EVT_OVF <= 1'b0;
        end
    end

    // FIFO storage and pointer updates.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[FIFO_AW-1:0]] <= pcode_q[sel];
                wr_ptr                   <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign EVT_VALID = !empty;
    assign EVT_CODE  = empty ? 3'b000 : mem[rd_ptr[FIFO_AW-1:0]];

`ifdef PSW_EVT_CNT_EN
    // Count of events accepted by the consumer, wrapping at 255.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            EVT_CNT <= 8'd0;
        end else if (pop) begin
            EVT_CNT <= EVT_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_psw_evt_dec.sv
// Testbench for psw_evt_dec with a short double-press window (DBL_WIN=8).
module tb_psw_evt_dec;

    localparam int DBL_WIN = 8;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [3:0] PSW_SIG;
    logic       EVT_ACK;
    logic       OVF_CLR;
    logic       EVT_VALID;
    logic [2:0] EVT_CODE;
    logic       EVT_OVF;
`ifdef PSW_EVT_CNT_EN
    logic [7:0] EVT_CNT;
`endif

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        int         key;
        int         gap;   // 0 = single press, else cycles to second pulse
        logic [2:0] code;
        int         lat;   // cycles from first pulse to EVT_VALID
    } vec_t;

    vec_t vecs[7];

    psw_evt_dec #(.DBL_WIN(DBL_WIN)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .PSW_SIG   (PSW_SIG),
        .EVT_ACK   (EVT_ACK),
        .OVF_CLR   (OVF_CLR),
        .EVT_VALID (EVT_VALID),
        .EVT_CODE  (EVT_CODE),
        .EVT_OVF   (EVT_OVF)
`ifdef PSW_EVT_CNT_EN
        ,
        .EVT_CNT   (EVT_CNT)
`endif
    );

    // Clock and cycle helper: outputs are sampled 1 time unit after the edge.
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one table vector, wait for its event, pop it and check quiet after.
    task automatic run_vec(input vec_t v);
        int         c;
        int         extra;
        logic       seen;
        logic [2:0] exp_code;
        exp_q.push_back(v.code);
        PSW_SIG = 4'b0001 << v.key;
        c       = 0;
        seen    = 1'b0;
        while (!seen && c < 40) begin
            tick();
            c++;
            PSW_SIG = 4'b0000;
            if (EVT_VALID) seen = 1'b1;
            else if (v.gap > 0 && c == v.gap) PSW_SIG = 4'b0001 << v.key;
        end
        check("latency", c, v.lat);
        exp_code = exp_q.pop_front();
        if (seen) begin
            EVT_ACK = 1'b1;
            check("code", int'(EVT_CODE), int'(exp_code));
            pops++;
            tick();
            EVT_ACK = 1'b0;
            check("valid_drop", int'(EVT_VALID), 0);
        end
        extra = 0;
        repeat (DBL_WIN + 4) begin
            tick();
            if (EVT_VALID) extra++;
        end
        check("no_extra_event", extra, 0);
    endtask

    initial begin
        int         c;
        int         extra;
        logic [2:0] exp_code;

        vecs[0] = '{key: 1, gap: 0, code: 3'b001, lat: DBL_WIN + 2};
        vecs[1] = '{key: 2, gap: 4, code: 3'b110, lat: 6};
        vecs[2] = '{key: 0, gap: 1, code: 3'b100, lat: 3};
        vecs[3] = '{key: 3, gap: DBL_WIN, code: 3'b111, lat: DBL_WIN + 2};
        vecs[4] = '{key: 3, gap: 0, code: 3'b011, lat: DBL_WIN + 2};
        vecs[5] = '{key: 0, gap: 0, code: 3'b000, lat: DBL_WIN + 2};
        vecs[6] = '{key: 2, gap: DBL_WIN - 1, code: 3'b110, lat: DBL_WIN + 1};

        // Reset held with toggling inputs: outputs stay idle.
        RSTN    = 1'b0;
        PSW_SIG = 4'b0000;
        EVT_ACK = 1'b0;
        OVF_CLR = 1'b0;
        repeat (6) begin
            PSW_SIG = 4'($urandom_range(0, 15));
            tick();
            check("rst_valid", int'(EVT_VALID), 0);
            check("rst_code", int'(EVT_CODE), 0);
            check("rst_ovf", int'(EVT_OVF), 0);
        end
        PSW_SIG = 4'b0000;
        RSTN    = 1'b1;
        // Idle after release, with ACK asserted while empty (must be ignored).
        extra   = 0;
        EVT_ACK = 1'b1;
        repeat (12) begin
            tick();
            if (EVT_VALID || EVT_CODE != 3'b000 || EVT_OVF) extra++;
        end
        EVT_ACK = 1'b0;
        check("idle_after_reset", extra, 0);

        // Table-driven single/double presses.
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Contention: keys 0 and 3 double-press together.
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b111);
        PSW_SIG = 4'b1001;
        c       = 0;
        while (!EVT_VALID && c < 40) begin
            tick();
            c++;
            PSW_SIG = (c == 4) ? 4'b1001 : 4'b0000;
        end
        check("cont_latency", c, 6);
        EVT_ACK  = 1'b1;
        exp_code = exp_q.pop_front();
        check("cont_code0", int'(EVT_CODE), int'(exp_code));
        pops++;
        tick();
        exp_code = exp_q.pop_front();
        check("cont_valid1", int'(EVT_VALID), 1);
        check("cont_code1", int'(EVT_CODE), int'(exp_code));
        pops++;
        tick();
        EVT_ACK = 1'b0;
        check("cont_empty", int'(EVT_VALID), 0);
        repeat (DBL_WIN + 4) tick();

        // Full FIFO: four singles fill it, two more stay pending.
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b011);
        PSW_SIG = 4'b1111;
        tick();
        PSW_SIG = 4'b0000;
        repeat (13) tick();
        check("full_valid", int'(EVT_VALID), 1);
        check("full_head", int'(EVT_CODE), 0);
        PSW_SIG = 4'b0011;
        tick();
        PSW_SIG = 4'b0000;
        repeat (10) tick();
        check("pend_no_ovf", int'(EVT_OVF), 0);
        check("pend_head", int'(EVT_CODE), 0);
        // Double press on key 0 while its single is still pending: overflow,
        // newer DOUBLE code replaces it ahead of key 1's pending single.
        PSW_SIG = 4'b0001;
        tick();
        PSW_SIG = 4'b0000;
        tick();
        PSW_SIG = 4'b0001;
        tick();
        PSW_SIG = 4'b0000;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        check("ovf_set", int'(EVT_OVF), 1);
        // Drain everything in order with ACK held.
        EVT_ACK = 1'b1;
        c       = 0;
        while (exp_q.size() > 0 && c < 40) begin
            if (EVT_VALID) begin
                exp_code = exp_q.pop_front();
                check("drain_code", int'(EVT_CODE), int'(exp_code));
                pops++;
            end
            tick();
            c++;
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        EVT_ACK = 1'b0;
        tick();
        check("drain_empty", int'(EVT_VALID), 0);
        check("ovf_sticky", int'(EVT_OVF), 1);
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("ovf_clear", int'(EVT_OVF), 0);
`ifdef PSW_EVT_CNT_EN
        check("evt_cnt", int'(EVT_CNT), pops % 256);
`endif

        // Reset in the middle of a WAIT2 window: nothing ever comes out.
        PSW_SIG = 4'b0001;
        tick();
        PSW_SIG = 4'b0000;
        tick();
        tick();
        RSTN = 1'b0;
        tick();
        tick();
        RSTN  = 1'b1;
        extra = 0;
        repeat (2 * DBL_WIN + 4) begin
            tick();
            if (EVT_VALID) extra++;
        end
        check("rst_mid_no_event", extra, 0);
        check("rst_mid_ovf", int'(EVT_OVF), 0);
`ifdef PSW_EVT_CNT_EN
        check("rst_mid_cnt", int'(EVT_CNT), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psw_evt_dec.md
Name: psw_evt_dec

Overview:
- Consumer of the debounced push-switch pulses (PSW_SIG[3:0], one-cycle high pulses).
- Classifies each key's activity as a SINGLE or DOUBLE press using a per-key time window.
- Encodes the result as an event code and queues it in a small FIFO.
- Presents events to the processor/control logic with a VALID/ACK handshake.

Parameters:
- DBL_WIN, 8'd200 (sim) / 5_000_000 (board), double-press window in CLK cycles; must be >= 2.
- CNT_W, 23, width of the per-key window counter; must hold DBL_WIN-1.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4).

Ports:
- CLK  input  1  system clock
- RSTN  input  1  asynchronous active-low reset
- PSW_SIG  input  4  debounced press pulses, one cycle high per press
- EVT_ACK  input  1  consumer accepts the head event
- OVF_CLR  input  1  clears EVT_OVF
- EVT_VALID  output  1  FIFO non-empty
- EVT_CODE  output  3  {type, key[1:0]}; type 0 = single, 1 = double
- EVT_OVF  output  1  sticky flag: an event was lost

Behaviour:
- Reset (async, RSTN=0):
  - all key FSMs go to IDLE; counters, pending flags and FIFO pointers clear to 0.
  - EVT_VALID=0, EVT_CODE=3'b000, EVT_OVF=0.
- Per-key FSM (4 independent copies), evaluated each cycle:
  - IDLE: PSW_SIG[k]=1 -> WAIT2, cnt <= DBL_WIN-1.
  - WAIT2, PSW_SIG[k]=1 -> emit DOUBLE, go to IDLE. This takes priority even if cnt==0 in the same cycle.
  - WAIT2, cnt==0, no pulse -> emit SINGLE, go to IDLE.
  - WAIT2, otherwise -> cnt <= cnt-1.
- Resulting timing: a SINGLE is emitted in the cycle DBL_WIN cycles after the press cycle.
- Emit: on the edge ending the emit cycle, pend[k] <= 1 and pcode[k] <= {type,k}.
- Arbiter:
  - each cycle, selects the lowest k with pend[k]=1.
  - if the FIFO is not full, writes pcode[k] on the next edge and clears pend[k].
  - at most one write per cycle.
- Full FIFO: a write is blocked when the FIFO is full, even if a pop happens in the same cycle. Blocked events stay pending.
- Overflow:
  - condition: a new emit for key k while pend[k]=1 and key k is not being written that cycle.
  - result: pcode[k] is overwritten with the newer event and EVT_OVF <= 1.
  - EVT_OVF holds until OVF_CLR=1. If set and clear coincide, the set wins.
- FIFO:
  - EVT_VALID = !empty; EVT_CODE = head entry. Both come from registered state, with no combinational path from inputs.
  - EVT_CODE reads 3'b000 when empty.
  - pop when EVT_VALID && EVT_ACK; EVT_ACK while empty is ignored.
  - pointers wrap modulo the depth; a full/empty extra bit distinguishes the two states.
  - simultaneous push and pop when non-empty: count is unchanged, order is preserved.
- Latency:
  - from emit cycle E: pend is visible at E+1, the FIFO write occurs at the edge ending E+1, and EVT_VALID=1 at E+2 (FIFO was empty, no contention).
  - so a DOUBLE becomes visible 2 cycles after the second pulse.
- Reset mid-operation: discards WAIT2 state, pending events and FIFO contents; no event is produced afterwards.

Optional Feature:
- Macro: PSW_EVT_CNT_EN.
- Defined:
  - adds output EVT_CNT [7:0], a count of events popped (VALID&&ACK).
  - wraps 255->0; reset value 0; unaffected by OVF_CLR.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold RSTN=0 with PSW_SIG toggling -> EVT_VALID=0, EVT_CODE=000, EVT_OVF=0 throughout. Release: still idle until the first pulse.
- Single press (DBL_WIN=8): PSW_SIG[1] pulse in cycle 0 -> EVT_VALID=1 in cycle 10 with EVT_CODE=3'b001. ACK in cycle 10 -> EVT_VALID=0 in cycle 11.
- Double press: PSW_SIG[2] pulses in cycles 0 and 4 -> EVT_VALID=1 in cycle 6, EVT_CODE=3'b110. No SINGLE follows.
- Contention: PSW_SIG[0] and PSW_SIG[3] each double-pulse in the same cycles -> events are 3'b100 then 3'b111, on consecutive FIFO writes. Also: a pulse exactly at cnt==0 gives DOUBLE.
- Full/overflow:
  - 6 single presses spread across keys 0..3, no ACK -> 4 events queued, the rest held pending.
  - a further emit on an already-pending key -> EVT_OVF=1 and the newer code is kept.
  - ACK drains all events in order; OVF_CLR clears the flag.
- Reset mid-WAIT2: PSW_SIG[0] pulse, then RSTN=0 for 2 cycles before timeout -> no event ever appears. With PSW_EVT_CNT_EN defined, EVT_CNT=0.
